icache_sa_controller: RTL and testbench
=======================================

// Module: icache_sa_controller
// PURPOSE
//  Self-contained N-way set-associative instruction cache: tag/valid/data arrays plus control FSM.
//  Sits between the CPU fetch port and the word-wide memory read port.
//  Adds over the direct-mapped controller:
//   - configurable ways with per-set round-robin replacement
//   - critical-word-first wrapping burst fill
//   - full-cache flush (fence.i)
// PARAMETERS
//  ADDR_WIDTH   32  word address width (CPU_ADDRESS/MEM_ADDRESS are word addresses)
//  DATA_WIDTH   32  instruction/word width
//  INDEX_WIDTH  5   log2(sets)
//  BLOCK_WORDS  4   words per line, power of 2, >=2
//  WAYS         2   associativity, power of 2, 1..8
//  OFFSET_WIDTH $clog2(BLOCK_WORDS); TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH
// PORTS
//  clk                 in   1           rising-edge clock
//  reset               in   1           asynchronous, active-low reset
//  CPU_READ            in   1           fetch request; hold with CPU_ADDRESS until CPU_BUSYWAIT=0
//  CPU_ADDRESS         in   ADDR_WIDTH  fetch word address
//  CPU_FLUSH           in   1           invalidate all lines (sampled in IDLE only)
//  CPU_INSTR           out  DATA_WIDTH  fetched word; valid when CPU_READ & !CPU_BUSYWAIT
//  CPU_BUSYWAIT        out  1           stall CPU
//  MEM_READ_REQ        out  1           line request; accepted on a cycle with !MEM_BUSYWAIT
//  MEM_ADDRESS         out  ADDR_WIDTH  {tag,index,critical offset}; stable while MEM_READ_REQ=1
//  MEM_BUSYWAIT        in   1           memory not ready to accept a request
//  MEM_READDATA        in   DATA_WIDTH  burst beat data
//  MEM_READDATA_VALID  in   1           one beat per cycle when high; BLOCK_WORDS beats in wrap order
// BEHAVIOUR
//  Reset (reset=0, any state):
//   - all valid bits and round-robin pointers = 0; FSM -> IDLE
//   - CPU_INSTR=0, CPU_BUSYWAIT=0, MEM_READ_REQ=0, MEM_ADDRESS=0
//   - any in-flight burst is abandoned; beats arriving after reset release are ignored
//  States: IDLE, LOOKUP, REQ, FILL, DONE, FLUSH.
//  IDLE:
//   - CPU_FLUSH has priority over CPU_READ -> FLUSH
//   - else CPU_READ: latch tag/index/offset, assert BUSYWAIT combinationally -> LOOKUP
//  LOOKUP: compare all ways of the set in parallel.
//   - hit: CPU_INSTR = hit way word, BUSYWAIT=0 -> IDLE (1 stall cycle per hit)
//   - miss: victim = lowest-numbered invalid way, else rr_ptr[index] -> REQ
//  REQ: MEM_READ_REQ=1, MEM_ADDRESS={tag,index,offset}.
//   - go to FILL on the cycle where !MEM_BUSYWAIT
//   - the victim's valid bit is cleared on entry to REQ
//  FILL: on each MEM_READDATA_VALID, write beat to data[victim][index][beat_off].
//   - beat_off starts at req offset, increments mod BLOCK_WORDS (wrap)
//   - on the final (BLOCK_WORDS-th) beat: set tag+valid; rr_ptr[index] = victim+1 mod WAYS
//     (only if the victim was not an invalid way) -> DONE
//   - VALID low cycles are legal gaps; beat counter unchanged
//  DONE: CPU_INSTR = requested word from array, BUSYWAIT=0 -> IDLE.
//  FLUSH: clear valid of one set per cycle, index 0..2^INDEX_WIDTH-1, BUSYWAIT=1 -> IDLE after last set.
//   - CPU_READ during FLUSH is held off; serviced after return to IDLE
//  Boundaries / rules:
//   - MEM_READDATA_VALID outside FILL is ignored
//   - WAYS=1 degenerates to direct-mapped (victim always way 0)
//   - address arithmetic is unsigned, offset wrap is modulo BLOCK_WORDS
// CONFIGURATION
//  ICACHE_EARLY_RESTART_EN defined:
//   - in FILL, on the beat whose offset equals the requested offset (always the first beat),
//     CPU_INSTR = MEM_READDATA and BUSYWAIT=0 for that cycle
//   - remaining beats fill with BUSYWAIT=1 for any new CPU_READ
//   - DONE skips the CPU response and returns straight to IDLE
//  Not defined: CPU is released only in DONE (BLOCK_WORDS beats + 1 cycle after the first beat).
// TESTING
//  1 Cold miss, addr 0x0000_0012, BLOCK_WORDS=4:
//    MEM_ADDRESS=0x12; beats at offsets 2,3,0,1; CPU_INSTR = beat 0 data; refetch 0x10 hits after 1 stall.
//  2 Two lines, same index, WAYS=2: both hit afterwards.
//    Third line in that index evicts way 0, fourth evicts way 1 (round-robin).
//  3 MEM_BUSYWAIT high 5 cycles in REQ: MEM_READ_REQ and MEM_ADDRESS held stable;
//    FILL entered the first cycle after it drops.
//  4 Gapped burst (VALID 1,0,0,1,1,0,1): line complete after 4 beats; correct word order in array.
//  5 CPU_FLUSH and CPU_READ together in IDLE: flush wins, 32 busy cycles;
//    the read then misses on a previously valid line.
//  6 reset low mid-FILL: all outputs 0, next read misses.
//    With ICACHE_EARLY_RESTART_EN: CPU released on the first beat.

Source files
------------

// File: rtl/icache_sa_controller.sv
// N-way set-associative instruction cache with round-robin replacement, critical-word-first
// wrapping fill and full flush. Define ICACHE_EARLY_RESTART_EN to release the CPU on the first fill beat.
module icache_sa_controller #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 5,
    parameter int BLOCK_WORDS  = 4,
    parameter int WAYS         = 2,
    parameter int OFFSET_WIDTH = $clog2(BLOCK_WORDS),
    parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CPU_READ,
    input  logic [ADDR_WIDTH-1:0] CPU_ADDRESS,
    input  logic                  CPU_FLUSH,
    output logic [DATA_WIDTH-1:0] CPU_INSTR,
    output logic                  CPU_BUSYWAIT,
    output logic                  MEM_READ_REQ,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    input  logic                  MEM_BUSYWAIT,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_READDATA_VALID
);
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REQ, S_FILL, S_DONE, S_FLUSH} state_t;

    state_t state, state_n;

    logic [SETS-1:0]       valid   [WAYS];
    logic [WAY_W-1:0]      rr_ptr  [SETS];
    logic [TAG_WIDTH-1:0]  tag_mem [WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_mem[WAYS][SETS][BLOCK_WORDS];

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [OFFSET_WIDTH-1:0] req_offset;
    logic [WAY_W-1:0]        victim;
    logic                    victim_was_free;
    logic [OFFSET_WIDTH-1:0] beat_off;
    logic [OFFSET_WIDTH-1:0] beat_cnt;
    logic [INDEX_WIDTH-1:0]  flush_idx;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             found_free;
    logic [WAY_W-1:0] victim_sel;
    logic             last_beat;
    logic [WAY_W-1:0] rr_next;

    assign last_beat = MEM_READDATA_VALID && (beat_cnt == OFFSET_WIDTH'(BLOCK_WORDS - 1));
    assign rr_next   = (WAYS == 1) ? '0 : victim + WAY_W'(1);

    // Parallel tag compare and victim choice (first free way, else round-robin pointer)
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        found_free = 1'b0;
        victim_sel = rr_ptr[req_index];
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid[w][req_index] && (tag_mem[w][req_index] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found_free && !valid[w][req_index]) begin
                found_free = 1'b1;
                victim_sel = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_n      = state;
        CPU_INSTR    = '0;
        CPU_BUSYWAIT = 1'b0;
        MEM_READ_REQ = 1'b0;
        MEM_ADDRESS  = '0;
        unique case (state)
            S_IDLE: begin
                CPU_BUSYWAIT = CPU_READ || CPU_FLUSH;
                if (CPU_FLUSH)     state_n = S_FLUSH;
                else if (CPU_READ) state_n = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    CPU_INSTR = data_mem[hit_way][req_index][req_offset];
                    state_n   = S_IDLE;
                end else begin
                    CPU_BUSYWAIT = 1'b1;
                    state_n      = S_REQ;
                end
            end
            S_REQ: begin
                CPU_BUSYWAIT = 1'b1;
                MEM_READ_REQ = 1'b1;
                MEM_ADDRESS  = {req_tag, req_index, req_offset};
                if (!MEM_BUSYWAIT) state_n = S_FILL;
            end
            S_FILL: begin
                CPU_BUSYWAIT = 1'b1;
`ifdef ICACHE_EARLY_RESTART_EN
                // The first beat of a wrapping burst is always the requested word
                if (MEM_READDATA_VALID && (beat_cnt == '0)) begin
                    CPU_INSTR    = MEM_READDATA;
                    CPU_BUSYWAIT = 1'b0;
                end
`endif
                if (last_beat) state_n = S_DONE;
            end
            S_DONE: begin
`ifdef ICACHE_EARLY_RESTART_EN
                CPU_BUSYWAIT = CPU_READ;
`else
                CPU_INSTR = data_mem[victim][req_index][req_offset];
`endif
                state_n = S_IDLE;
            end
            S_FLUSH: begin
                CPU_BUSYWAIT = 1'b1;
                if (flush_idx == INDEX_WIDTH'(SETS - 1)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (!reset) begin
            CPU_INSTR    = '0;
            CPU_BUSYWAIT = 1'b0;
            MEM_READ_REQ = 1'b0;
            MEM_ADDRESS  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            flush_idx <= '0;
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                S_LOOKUP: begin
                    if (!hit) begin
                        valid[victim_sel][req_index] <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                S_FILL: begin
                    if (MEM_READDATA_VALID) beat_cnt <= beat_cnt + 1'b1;
                    if (last_beat) begin
                        valid[victim][req_index] <= 1'b1;
                        if (!victim_was_free) rr_ptr[req_index] <= rr_next;
                    end
                end
                S_FLUSH: begin
                    for (int w = 0; w < WAYS; w++) valid[w][flush_idx] <= 1'b0;
                    flush_idx <= flush_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Request latches and arrays carry no reset; validity is tracked by the control state above
    always_ff @(posedge clk) begin
        if (state == S_IDLE && CPU_READ && !CPU_FLUSH) begin
            req_tag    <= CPU_ADDRESS[ADDR_WIDTH-1 -: TAG_WIDTH];
            req_index  <= CPU_ADDRESS[OFFSET_WIDTH +: INDEX_WIDTH];
            req_offset <= CPU_ADDRESS[OFFSET_WIDTH-1:0];
        end
        if (state == S_LOOKUP && !hit) begin
            victim          <= victim_sel;
            victim_was_free <= found_free;
            beat_off        <= req_offset;
        end
        if (state == S_FILL && MEM_READDATA_VALID) begin
            data_mem[victim][req_index][beat_off] <= MEM_READDATA;
            beat_off <= beat_off + 1'b1;
            if (last_beat) tag_mem[victim][req_index] <= req_tag;
        end
    end

endmodule

// File: tb/tb_icache_sa_controller.sv
// Directed bench for icache_sa_controller: vector table of fetches plus hand-written
// sequences for memory stalls, gapped bursts, flush and reset during fill.
module tb_icache_sa_controller;
    logic        clk;
    logic        reset;
    logic        CPU_READ;
    logic [31:0] CPU_ADDRESS;
    logic        CPU_FLUSH;
    logic [31:0] CPU_INSTR;
    logic        CPU_BUSYWAIT;
    logic        MEM_READ_REQ;
    logic [31:0] MEM_ADDRESS;
    logic        MEM_BUSYWAIT;
    logic [31:0] MEM_READDATA;
    logic        MEM_READDATA_VALID;

    icache_sa_controller dut (
        .clk(clk), .reset(reset),
        .CPU_READ(CPU_READ), .CPU_ADDRESS(CPU_ADDRESS), .CPU_FLUSH(CPU_FLUSH),
        .CPU_INSTR(CPU_INSTR), .CPU_BUSYWAIT(CPU_BUSYWAIT),
        .MEM_READ_REQ(MEM_READ_REQ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .MEM_READDATA(MEM_READDATA), .MEM_READDATA_VALID(MEM_READDATA_VALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ICACHE_EARLY_RESTART_EN
    localparam int EXP_MISS  = 3;
    localparam int EXP_GAP   = 3;
    localparam int EXP_BUSY5 = 8;
`else
    localparam int EXP_MISS  = 7;
    localparam int EXP_GAP   = 10;
    localparam int EXP_BUSY5 = 12;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        bit          exp_hit;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One CPU fetch with a memory responder; pat gives VALID per burst cycle, LSB first
    task automatic fetch(input logic [31:0] addr, input int busy_n, input logic [15:0] pat,
                         input bit flush, output logic [31:0] instr, output bit missed,
                         output logic [31:0] maddr, output int stalls, output int req_first,
                         output int req_cycles, output bit addr_stable, output bit timed_out);
        int cyc = 0;
        int beat_i = 0;
        int gi = 0;
        int busy_left = busy_n;
        bit started = 0;
        bit accept = 0;
        bit released = 0;
        logic [1:0] off;
        instr = '0; missed = 0; maddr = '0; stalls = 0; req_first = -1;
        req_cycles = 0; addr_stable = 1; timed_out = 0;
        @(negedge clk);
        CPU_READ = 1'b1;
        CPU_ADDRESS = addr;
        CPU_FLUSH = flush;
        while (cyc < 300) begin
            if (accept) started = 1;
            accept = 0;
            MEM_BUSYWAIT = (busy_left > 0);
            MEM_READDATA_VALID = 1'b0;
            MEM_READDATA = '0;
            if (started && beat_i < 4 && pat[gi]) begin
                off = addr[1:0] + 2'(beat_i);
                MEM_READDATA_VALID = 1'b1;
                MEM_READDATA = mem_word({addr[31:2], off});
            end
            #1;
            if (MEM_READ_REQ) begin
                if (req_cycles == 0) begin
                    missed = 1;
                    maddr = MEM_ADDRESS;
                    req_first = cyc;
                end else if (MEM_ADDRESS !== maddr) begin
                    addr_stable = 0;
                end
                req_cycles++;
                if (MEM_BUSYWAIT) busy_left--;
                else accept = 1;
            end
            if (started && beat_i < 4) begin
                if (MEM_READDATA_VALID) beat_i++;
                if (gi < 15) gi++;
            end
            if (!released) begin
                if (CPU_BUSYWAIT) stalls++;
                else begin
                    released = 1;
                    instr = CPU_INSTR;
                end
            end
            cyc++;
            if (released && (!missed || beat_i == 4)) break;
            @(negedge clk);
            CPU_FLUSH = 1'b0;
            if (released) CPU_READ = 1'b0;
        end
        timed_out = !released || (missed && beat_i < 4);
        @(negedge clk);
        CPU_READ = 1'b0;
        CPU_FLUSH = 1'b0;
        MEM_READDATA_VALID = 1'b0;
        MEM_BUSYWAIT = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [31:0] instr, maddr;
    bit          missed, stable, tout, got_req;
    int          stalls, rfirst, rcyc;

    initial begin
        tbl[0]  = '{32'h0000_0012, 1'b0};
        tbl[1]  = '{32'h0000_0010, 1'b1};
        tbl[2]  = '{32'h0000_0011, 1'b1};
        tbl[3]  = '{32'h0000_0013, 1'b1};
        tbl[4]  = '{32'h0000_0090, 1'b0};
        tbl[5]  = '{32'h0000_0010, 1'b1};
        tbl[6]  = '{32'h0000_0093, 1'b1};
        tbl[7]  = '{32'h0000_0110, 1'b0};
        tbl[8]  = '{32'h0000_0090, 1'b1};
        tbl[9]  = '{32'h0000_0010, 1'b0};
        tbl[10] = '{32'h0000_0110, 1'b1};
        tbl[11] = '{32'h0000_0090, 1'b0};
        tbl[12] = '{32'h0000_0010, 1'b1};
        tbl[13] = '{32'h0000_0110, 1'b0};
        tbl[14] = '{32'h0000_002A, 1'b0};
        tbl[15] = '{32'h0000_002A, 1'b1};

        reset = 1'b0;
        CPU_READ = 1'b1;
        CPU_ADDRESS = 32'h12;
        CPU_FLUSH = 1'b0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        MEM_READDATA_VALID = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk32("reset instr", CPU_INSTR, 32'h0);
        chk32("reset busywait", {31'b0, CPU_BUSYWAIT}, 32'h0);
        chk32("reset mem_req", {31'b0, MEM_READ_REQ}, 32'h0);
        chk32("reset mem_addr", MEM_ADDRESS, 32'h0);
        @(negedge clk);
        CPU_READ = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Cold miss, hits, then round-robin eviction within index 4
        for (int i = 0; i < 16; i++) begin
            fetch(tbl[i].addr, 0, 16'hFFFF, 1'b0, instr, missed, maddr, stalls, rfirst, rcyc, stable, tout);
            chk_int($sformatf("vec%0d timeout", i), int'(tout), 0);
            chk32($sformatf("vec%0d instr", i), instr, mem_word(tbl[i].addr));
            chk_int($sformatf("vec%0d hit", i), int'(!missed), int'(tbl[i].exp_hit));
            chk_int($sformatf("vec%0d stalls", i), stalls, tbl[i].exp_hit ? 1 : EXP_MISS);
            if (!tbl[i].exp_hit) chk32($sformatf("vec%0d mem_addr", i), maddr, tbl[i].addr);
        end

        // Memory holds off the request for 5 cycles
        fetch(32'h203, 5, 16'hFFFF, 1'b0, instr, missed, maddr, stalls, rfirst, rcyc, stable, tout);
        chk_int("busy5 timeout", int'(tout), 0);
        chk_int("busy5 req cycles", rcyc, 6);
        chk_int("busy5 addr stable", int'(stable), 1);
        chk32("busy5 mem_addr", maddr, 32'h203);
        chk32("busy5 instr", instr, mem_word(32'h203));
        chk_int("busy5 stalls", stalls, EXP_BUSY5);

        // Gapped burst VALID 1,0,0,1,1,0,1 then the rest of the line must hit in order
        fetch(32'h305, 0, 16'hFFD9, 1'b0, instr, missed, maddr, stalls, rfirst, rcyc, stable, tout);
        chk_int("gap timeout", int'(tout), 0);
        chk32("gap instr", instr, mem_word(32'h305));
        chk_int("gap stalls", stalls, EXP_GAP);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = 32'h304 + 32'(k);
            fetch(a, 0, 16'hFFFF, 1'b0, instr, missed, maddr, stalls, rfirst, rcyc, stable, tout);
            chk32($sformatf("gap word%0d", k), instr, mem_word(a));
            chk_int($sformatf("gap hit%0d", k), int'(missed), 0);
        end

        // Flush and read together: flush wins, then the valid line at 0x2A misses
        fetch(32'h2A, 0, 16'hFFFF, 1'b1, instr, missed, maddr, stalls, rfirst, rcyc, stable, tout);
        chk_int("flush timeout", int'(tout), 0);
        chk_int("flush miss", int'(missed), 1);
        chk_int("flush req cycle", rfirst, 35);
        chk32("flush instr", instr, mem_word(32'h2A));

        // Reset asserted mid-fill
        @(negedge clk);
        CPU_READ = 1'b1;
        CPU_ADDRESS = 32'h48;
        got_req = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (MEM_READ_REQ) begin
                got_req = 1;
                break;
            end
            @(negedge clk);
        end
        chk_int("rst req seen", int'(got_req), 1);
        @(negedge clk);
        MEM_READDATA_VALID = 1'b1;
        MEM_READDATA = mem_word(32'h48);
        #1;
`ifdef ICACHE_EARLY_RESTART_EN
        chk32("early busywait", {31'b0, CPU_BUSYWAIT}, 32'h0);
        chk32("early instr", CPU_INSTR, mem_word(32'h48));
`else
        chk32("fill busywait", {31'b0, CPU_BUSYWAIT}, 32'h1);
`endif
        @(negedge clk);
        MEM_READDATA_VALID = 1'b0;
        reset = 1'b0;
        #1;
        chk32("midfill instr", CPU_INSTR, 32'h0);
        chk32("midfill busywait", {31'b0, CPU_BUSYWAIT}, 32'h0);
        chk32("midfill mem_req", {31'b0, MEM_READ_REQ}, 32'h0);
        chk32("midfill mem_addr", MEM_ADDRESS, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        CPU_READ = 1'b0;
        for (int c = 0; c < 3; c++) begin
            MEM_READDATA_VALID = 1'b1;
            MEM_READDATA = 32'hDEAD_0000 + 32'(c);
            @(negedge clk);
        end
        MEM_READDATA_VALID = 1'b0;
        @(negedge clk);
        fetch(32'h2A, 0, 16'hFFFF, 1'b0, instr, missed, maddr, stalls, rfirst, rcyc, stable, tout);
        chk_int("post-reset miss", int'(missed), 1);
        chk32("post-reset instr", instr, mem_word(32'h2A));
        fetch(32'h2A, 0, 16'hFFFF, 1'b0, instr, missed, maddr, stalls, rfirst, rcyc, stable, tout);
        chk_int("post-reset hit", int'(missed), 0);
        chk32("post-reset hit instr", instr, mem_word(32'h2A));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
